// File: rtl/cam_frame_writer.sv
// Frame-buffer writer: converts RGB565 pixels to RGB444, issues linear BRAM writes,
// and validates the pixel count of every frame.
module cam_frame_writer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              p_clock,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [15:0]       pixel_data,
   input  logic              pixel_valid,
   input  logic              frame_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              frame_ready,
   output logic              frame_err,
   output logic [7:0]        frame_count,
   output logic              busy
);

   localparam int FRAME_PIX = H_RES * V_RES;
   localparam int CNT_W     = $clog2(FRAME_PIX + 1);
   localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);

   typedef enum logic {SYNC, WRITE} state_t;

   state_t           state;
   logic [CNT_W-1:0] pix_cnt;
   logic             overflow;

   logic             accept;
   logic             dropped;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;
   logic             good;

   // The pixel arriving with frame_done is folded into the count before the check.
   always_comb begin
      accept   = 1'b0;
      dropped  = 1'b0;
      cnt_next = pix_cnt;
      ovf_next = overflow;
      good     = 1'b0;
      if (state == WRITE && pixel_valid) begin
         accept  = (pix_cnt < FRAME_PIX_C);
         dropped = !accept;
      end
      cnt_next = pix_cnt + {{(CNT_W-1){1'b0}}, accept};
      ovf_next = overflow | dropped;
      good     = (cnt_next == FRAME_PIX_C) && !ovf_next;
   end

   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SYNC;
         pix_cnt     <= '0;
         overflow    <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_ready <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         busy        <= 1'b0;
      end else begin
         wr_en       <= accept;
         frame_ready <= 1'b0;
         frame_err   <= 1'b0;
         if (accept) begin
            wr_addr <= ADDR_W'(pix_cnt);
            wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
         end
         case (state)
            SYNC: begin
               if (frame_done && enable) begin
                  state    <= WRITE;
                  busy     <= 1'b1;
                  pix_cnt  <= '0;
                  overflow <= 1'b0;
               end
            end
            WRITE: begin
               if (frame_done) begin
                  frame_ready <= good;
                  frame_err   <= !good;
                  if (good)
                     frame_count <= frame_count + 8'd1;
                  pix_cnt  <= '0;
                  overflow <= 1'b0;
                  if (!enable) begin
                     state <= SYNC;
                     busy  <= 1'b0;
                  end
               end else begin
                  pix_cnt  <= cnt_next;
                  overflow <= ovf_next;
               end
            end
            default: begin
               state <= SYNC;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
